ibex_ifetch_arbiter: RTL and testbench
======================================

IBEX_IFETCH_ARBITER -- requirements
Module: ibex_ifetch_arbiter

Interface
REQ-001 The block SHALL have parameter MaxOutstanding, default 2, giving the maximum number of granted but unanswered bus transactions (legal range 1..4).
REQ-002 The block SHALL have parameter FixedPriority, default 1'b0, where 0 selects round-robin arbitration and 1 gives requester 0 absolute priority.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports as follows.
REQ-004 clk_i  input  1  clock; every flop is rising-edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 For each requester m in {0,1}:
- m0 is the core fetch port (the prefetch buffer); m1 is the secondary loader/debug port.
- m<m>_req_i  input  1  request.
- m<m>_addr_i  input  32  fetch address.
- m<m>_gnt_o  output  1  grant.
- m<m>_rvalid_o  output  1  response valid.
- m<m>_rdata_o  output  32  response data.
- m<m>_err_o  output  1  response error.
REQ-007 Downstream port signals:
- bus_req_o  output  1.
- bus_addr_o  output  32.
- bus_gnt_i  input  1.
- bus_rvalid_i  input  1.
- bus_rdata_i  input  32.
- bus_err_i  input  1.
REQ-008 Status outputs:
- busy_o  output  1  at least one transaction outstanding or pending.
- unexp_rsp_o  output  1  one-cycle pulse when bus_rvalid_i arrives with nothing outstanding.

Function
REQ-009 Handshake: req/gnt address phase, rvalid data phase; a transfer occurs in a cycle with bus_req_o & bus_gnt_i.
REQ-010 Selection when unlocked:
- Round-robin: pointer rr_q names the preferred requester; if only one requester asserts req, it wins.
- FixedPriority=1: m0 always wins over m1.
REQ-011 Lock: if bus_req_o=1 and bus_gnt_i=0, the SHALL set lock_q and hold the selected requester, and bus_addr_o SHALL stay stable until that request's gnt.
REQ-012 The lock SHALL persist even if the other requester raises req meanwhile.
REQ-013 bus_req_o SHALL equal (selected m<m>_req_i) & ~stall; bus_addr_o SHALL equal the selected m<m>_addr_i, passed unchanged.
REQ-014 m<m>_gnt_o SHALL equal bus_gnt_i & bus_req_o & (selected==m); the non-selected requester SHALL see gnt=0.
REQ-015 On each transfer, the SHALL push the winning requester ID into an in-order ID FIFO of depth MaxOutstanding and, in round-robin mode, set rr_q to the other requester.
REQ-016 Outstanding count: count_next = count + push - pop.
REQ-017 stall SHALL be (count==MaxOutstanding) & ~bus_rvalid_i; a push and a pop in the same cycle when full SHALL be legal.
REQ-018 On bus_rvalid_i with a non-empty FIFO, the block SHALL pop the head ID and drive m<head>_rvalid_o=1 combinationally in the same cycle, with m<head>_rdata_o=bus_rdata_i and m<head>_err_o=bus_err_i.
REQ-019 The other requester's rvalid SHALL be 0, and its rdata/err SHALL also be driven from the bus.
REQ-020 On bus_rvalid_i with an empty FIFO, the block SHALL assert unexp_rsp_o for that cycle, route the response to no requester, and leave all state unchanged.
REQ-021 A requester dropping req while locked and ungranted is a protocol violation; the block SHALL keep bus_req_o low and hold lock_q until that requester reasserts req.
REQ-022 busy_o SHALL equal (count!=0) | bus_req_o.
REQ-023 Latency: gnt and rvalid paths SHALL add zero cycles; the only registered state is lock_q, sel_q, rr_q, count and the FIFO.

Reset
REQ-024 On rst_ni=0 the block SHALL asynchronously clear count, the FIFO pointers, lock_q, sel_q and rr_q (rr_q prefers m0).
REQ-025 During reset, all outputs SHALL evaluate to 0, including bus_req_o, grants, rvalids, busy_o and unexp_rsp_o.
REQ-026 Outstanding transactions at reset assertion SHALL be discarded; their later responses SHALL be handled per REQ-020.

Structure
REQ-027 The requester-ID type and the constant IFETCH_ARB_MAX_OUTSTANDING SHALL live in ibex_pkg.
REQ-028 The ID FIFO SHALL be a single sub-module, ibex_ifetch_arb_fifo (push/pop/full/empty/head, asynchronous reset, simultaneous push+pop supported when full or empty).
REQ-029 Total RTL SHALL be at most 300 lines.

Verification
REQ-030 Bus stalled then granted: m0 req, addr 0x0000_0080, bus_gnt_i=0 for 3 cycles, then m1 req asserted and gnt=1 → bus_addr_o stays 0x80 for all 4 cycles, m0_gnt_o=1 only in cycle 4, m1_gnt_o=0 throughout.
REQ-031 Round-robin alternation: both req every cycle, gnt always 1, rvalid 1 cycle later → grants alternate m0,m1,m0,m1; m1_rvalid_o data matches bus_rdata_i 0xDEAD_BEEF in its slot.
REQ-032 Outstanding limit: MaxOutstanding=2, m0 gets 2 grants with no rvalid → bus_req_o=0 in the 3rd cycle; rvalid with a pending req in the same cycle → 3rd grant taken that cycle, count stays 2.
REQ-033 Spurious response: bus_rvalid_i=1 with count=0 → unexp_rsp_o=1 for 1 cycle, m0_rvalid_o=m1_rvalid_o=0.
REQ-034 Response ordering: grants m1,m0, then rvalid with err=1 followed by rvalid with err=0 → m1_err_o=1 on the first response, m0_rvalid_o with err 0 on the second.
REQ-035 Reset mid-operation: rst_ni pulsed low with count=2 → count=0, bus_req_o=0 immediately; the next two rvalids each pulse unexp_rsp_o.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction-fetch arbiter.
// Requester IDs are stored in the response-ordering FIFO.
package ibex_pkg;

    localparam int unsigned IFETCH_ARB_MAX_OUTSTANDING = 2;

    typedef enum logic {
        IFETCH_REQ_M0 = 1'b0,
        IFETCH_REQ_M1 = 1'b1
    } ifetch_req_id_e;

    function automatic ifetch_req_id_e ifetch_other_id(input ifetch_req_id_e id);
        return (id == IFETCH_REQ_M0) ? IFETCH_REQ_M1 : IFETCH_REQ_M0;
    endfunction

endpackage

// File: rtl/ibex_ifetch_arb_fifo.sv
// In-order requester-ID FIFO: records who owns each granted, unanswered bus transaction.
// A push and a pop in the same cycle are accepted when the FIFO is full.
module ibex_ifetch_arb_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = IFETCH_ARB_MAX_OUTSTANDING
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  ifetch_req_id_e               push_id_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output ifetch_req_id_e               head_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    ifetch_req_id_e  mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push_eff;
    logic            pop_eff;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o   = (count_q == DepthCnt);
    assign empty_o  = (count_q == '0);
    assign head_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;

    // An empty FIFO has nothing to pop; a full one only accepts a push alongside a pop.
    assign pop_eff  = pop_i & ~empty_o;
    assign push_eff = push_i & (~full_o | pop_eff);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_eff)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CntW'(push_eff) - CntW'(pop_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/ibex_ifetch_arbiter.sv
// Two-requester instruction-fetch arbiter onto a single req/gnt/rvalid bus.
// Grants and responses are purely combinational; responses are routed in grant order.
//
// lock_q | meaning
// 0      | unlocked: requester chosen each cycle by round-robin or fixed priority
// 1      | locked: request to sel_q is pending without gnt, address held stable
module ibex_ifetch_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = IFETCH_ARB_MAX_OUTSTANDING,
    parameter bit          FixedPriority  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,

    output logic        busy_o,
    output logic        unexp_rsp_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic           lock_q;
    ifetch_req_id_e sel_q;
    ifetch_req_id_e rr_q;
    ifetch_req_id_e sel;
    ifetch_req_id_e fifo_head;
    logic           sel_req;
    logic [31:0]    sel_addr;
    logic           stall;
    logic           xfer;
    logic           rsp_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CntW-1:0] fifo_count;

    always_comb begin
        sel = rr_q;
        if (lock_q) begin
            sel = sel_q;
        end else if (FixedPriority) begin
            sel = (m1_req_i && !m0_req_i) ? IFETCH_REQ_M1 : IFETCH_REQ_M0;
        end else if (m0_req_i && !m1_req_i) begin
            sel = IFETCH_REQ_M0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = IFETCH_REQ_M1;
        end
    end

    assign sel_req  = (sel == IFETCH_REQ_M1) ? m1_req_i  : m0_req_i;
    assign sel_addr = (sel == IFETCH_REQ_M1) ? m1_addr_i : m0_addr_i;

    // A response arriving this cycle frees a slot, so a full FIFO can still take a grant.
    assign stall   = fifo_full & ~bus_rvalid_i;
    assign xfer    = bus_req_o & bus_gnt_i;
    assign rsp_pop = rst_ni & bus_rvalid_i & ~fifo_empty;

    assign bus_req_o   = rst_ni & sel_req & ~stall;
    assign bus_addr_o  = rst_ni ? sel_addr : '0;

    assign m0_gnt_o    = xfer & (sel == IFETCH_REQ_M0);
    assign m1_gnt_o    = xfer & (sel == IFETCH_REQ_M1);

    assign m0_rvalid_o = rsp_pop & (fifo_head == IFETCH_REQ_M0);
    assign m1_rvalid_o = rsp_pop & (fifo_head == IFETCH_REQ_M1);
    assign m0_rdata_o  = rst_ni ? bus_rdata_i : '0;
    assign m1_rdata_o  = rst_ni ? bus_rdata_i : '0;
    assign m0_err_o    = rst_ni & bus_err_i;
    assign m1_err_o    = rst_ni & bus_err_i;

    assign unexp_rsp_o = rst_ni & bus_rvalid_i & fifo_empty;
    assign busy_o      = rst_ni & ((fifo_count != '0) | bus_req_o);

    // Lock stays set until the held requester is granted, even if it drops req meanwhile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            sel_q  <= IFETCH_REQ_M0;
            rr_q   <= IFETCH_REQ_M0;
        end else begin
            if (lock_q) begin
                if (xfer) lock_q <= 1'b0;
            end else if (bus_req_o && !bus_gnt_i) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end
            if (xfer && !FixedPriority) rr_q <= ifetch_other_id(sel);
        end
    end

    ibex_ifetch_arb_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (xfer),
        .push_id_i (sel),
        .pop_i     (rsp_pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_ibex_ifetch_arbiter.sv
// Directed bench for the instruction-fetch arbiter with hand-computed expectations.
module tb_ibex_ifetch_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        bus_req_o, bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_addr_o, bus_rdata_i;
    logic        busy_o, unexp_rsp_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ibex_ifetch_arbiter #(
        .MaxOutstanding (2),
        .FixedPriority  (1'b0)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m0_req_i     (m0_req_i),
        .m0_addr_i    (m0_addr_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m0_err_o     (m0_err_o),
        .m1_req_i     (m1_req_i),
        .m1_addr_i    (m1_addr_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .m1_err_o     (m1_err_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i),
        .busy_o       (busy_o),
        .unexp_rsp_o  (unexp_rsp_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle before checking.
    task automatic cyc(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                       input logic g, input logic rv, input logic [31:0] rd, input logic er);
        @(negedge clk_i);
        m0_req_i = r0; m0_addr_i = a0; m1_req_i = r1; m1_addr_i = a1;
        bus_gnt_i = g; bus_rvalid_i = rv; bus_rdata_i = rd; bus_err_i = er;
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m0_addr_i = '0; m1_req_i = 0; m1_addr_i = '0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0; bus_err_i = 0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();

        // Outputs forced low while in reset, despite active inputs
        cyc(1, 32'h80, 1, 32'h100, 1, 1, 32'hCAFE, 1);
        chk1("rst_bus_req", bus_req_o, 0);
        chk32("rst_bus_addr", bus_addr_o, 32'h0);
        chk1("rst_m0_gnt", m0_gnt_o, 0);
        chk1("rst_m1_gnt", m1_gnt_o, 0);
        chk1("rst_m0_rvalid", m0_rvalid_o, 0);
        chk1("rst_busy", busy_o, 0);
        chk1("rst_unexp", unexp_rsp_o, 0);
        chk32("rst_m0_rdata", m0_rdata_o, 32'h0);
        @(negedge clk_i); rst_ni = 1'b1; idle_inputs();

        // Bus stalled three cycles, then granted while m1 also requests
        cyc(1, 32'h80, 0, 0, 0, 0, 0, 0);
        chk1("stall1_req", bus_req_o, 1);
        chk32("stall1_addr", bus_addr_o, 32'h80);
        chk1("stall1_m0_gnt", m0_gnt_o, 0);
        chk1("stall1_busy", busy_o, 1);
        cyc(1, 32'h80, 0, 0, 0, 0, 0, 0);
        chk32("stall2_addr", bus_addr_o, 32'h80);
        chk1("stall2_m0_gnt", m0_gnt_o, 0);
        cyc(1, 32'h80, 0, 0, 0, 0, 0, 0);
        chk32("stall3_addr", bus_addr_o, 32'h80);
        chk1("stall3_m1_gnt", m1_gnt_o, 0);
        cyc(1, 32'h80, 1, 32'h100, 1, 0, 0, 0);
        chk32("stall4_addr", bus_addr_o, 32'h80);
        chk1("stall4_m0_gnt", m0_gnt_o, 1);
        chk1("stall4_m1_gnt", m1_gnt_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h1111_1111, 0);
        chk1("rsp1_m0_rvalid", m0_rvalid_o, 1);
        chk32("rsp1_m0_rdata", m0_rdata_o, 32'h1111_1111);
        chk1("rsp1_m1_rvalid", m1_rvalid_o, 0);
        chk1("rsp1_unexp", unexp_rsp_o, 0);

        // Lock on m0 holds even though round-robin now prefers m1
        cyc(1, 32'h200, 0, 0, 0, 0, 0, 0);
        chk32("lock1_addr", bus_addr_o, 32'h200);
        cyc(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
        chk32("lock2_addr", bus_addr_o, 32'h200);
        chk1("lock2_m1_gnt", m1_gnt_o, 0);
        cyc(1, 32'h200, 1, 32'h300, 1, 0, 0, 0);
        chk1("lock3_m0_gnt", m0_gnt_o, 1);
        chk1("lock3_m1_gnt", m1_gnt_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h2222_2222, 0);
        chk1("lock_rsp_m0_rvalid", m0_rvalid_o, 1);

        // Fresh reset so round-robin starts from m0
        @(negedge clk_i); rst_ni = 1'b0; idle_inputs();
        @(negedge clk_i); rst_ni = 1'b1;

        // Round-robin alternation with one-cycle response latency
        cyc(1, 32'hA0, 1, 32'hB0, 1, 0, 0, 0);
        chk1("rr1_m0_gnt", m0_gnt_o, 1);
        chk1("rr1_m1_gnt", m1_gnt_o, 0);
        chk32("rr1_addr", bus_addr_o, 32'hA0);
        cyc(1, 32'hA0, 1, 32'hB0, 1, 1, 32'h0000_A000, 0);
        chk1("rr2_m1_gnt", m1_gnt_o, 1);
        chk1("rr2_m0_gnt", m0_gnt_o, 0);
        chk32("rr2_addr", bus_addr_o, 32'hB0);
        chk1("rr2_m0_rvalid", m0_rvalid_o, 1);
        chk32("rr2_m0_rdata", m0_rdata_o, 32'h0000_A000);
        cyc(1, 32'hA0, 1, 32'hB0, 1, 1, 32'hDEAD_BEEF, 0);
        chk1("rr3_m0_gnt", m0_gnt_o, 1);
        chk1("rr3_m1_rvalid", m1_rvalid_o, 1);
        chk32("rr3_m1_rdata", m1_rdata_o, 32'hDEAD_BEEF);
        chk1("rr3_m0_rvalid", m0_rvalid_o, 0);
        cyc(1, 32'hA0, 1, 32'hB0, 1, 1, 32'h0000_C000, 0);
        chk1("rr4_m1_gnt", m1_gnt_o, 1);
        chk1("rr4_m0_rvalid", m0_rvalid_o, 1);
        cyc(0, 0, 0, 0, 0, 1, 32'h5555, 0);
        chk1("rr5_m1_rvalid", m1_rvalid_o, 1);
        chk1("rr5_busy", busy_o, 1);

        // Outstanding limit of two, then grant alongside a response
        cyc(1, 32'h400, 0, 0, 1, 0, 0, 0);
        chk1("lim1_m0_gnt", m0_gnt_o, 1);
        cyc(1, 32'h400, 0, 0, 1, 0, 0, 0);
        chk1("lim2_m0_gnt", m0_gnt_o, 1);
        cyc(1, 32'h400, 0, 0, 1, 0, 0, 0);
        chk1("lim3_bus_req", bus_req_o, 0);
        chk1("lim3_m0_gnt", m0_gnt_o, 0);
        chk1("lim3_busy", busy_o, 1);
        cyc(1, 32'h400, 0, 0, 1, 1, 32'h1234, 0);
        chk1("lim4_bus_req", bus_req_o, 1);
        chk1("lim4_m0_gnt", m0_gnt_o, 1);
        chk1("lim4_m0_rvalid", m0_rvalid_o, 1);
        chk32("lim4_m0_rdata", m0_rdata_o, 32'h1234);
        cyc(1, 32'h400, 0, 0, 1, 0, 0, 0);
        chk1("lim5_bus_req", bus_req_o, 0);

        // Reset with two outstanding: immediate quiet, later responses are unexpected
        @(negedge clk_i); rst_ni = 1'b0; #1;
        chk1("mrst_bus_req", bus_req_o, 0);
        chk1("mrst_busy", busy_o, 0);
        chk1("mrst_m0_gnt", m0_gnt_o, 0);
        @(negedge clk_i); rst_ni = 1'b1; idle_inputs(); #1;
        chk1("mrst_busy_after", busy_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h9999, 0);
        chk1("unexp1", unexp_rsp_o, 1);
        chk1("unexp1_m0_rvalid", m0_rvalid_o, 0);
        chk1("unexp1_m1_rvalid", m1_rvalid_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h9999, 0);
        chk1("unexp2", unexp_rsp_o, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk1("unexp_clear", unexp_rsp_o, 0);
        chk1("unexp_busy", busy_o, 0);

        // Responses return in grant order with per-response error
        cyc(0, 0, 1, 32'h600, 1, 0, 0, 0);
        chk1("ord1_m1_gnt", m1_gnt_o, 1);
        cyc(1, 32'h500, 0, 0, 1, 0, 0, 0);
        chk1("ord2_m0_gnt", m0_gnt_o, 1);
        cyc(0, 0, 0, 0, 0, 1, 32'h6666, 1);
        chk1("ord3_m1_rvalid", m1_rvalid_o, 1);
        chk1("ord3_m1_err", m1_err_o, 1);
        chk1("ord3_m0_rvalid", m0_rvalid_o, 0);
        chk32("ord3_m0_rdata", m0_rdata_o, 32'h6666);
        cyc(0, 0, 0, 0, 0, 1, 32'h5555, 0);
        chk1("ord4_m0_rvalid", m0_rvalid_o, 1);
        chk1("ord4_m0_err", m0_err_o, 0);
        chk1("ord4_m1_rvalid", m1_rvalid_o, 0);

        // Locked requester drops req: bus_req low, lock kept until it returns
        cyc(0, 0, 1, 32'h700, 0, 0, 0, 0);
        chk1("viol1_bus_req", bus_req_o, 1);
        chk32("viol1_addr", bus_addr_o, 32'h700);
        cyc(1, 32'h800, 0, 0, 1, 0, 0, 0);
        chk1("viol2_bus_req", bus_req_o, 0);
        chk1("viol2_m0_gnt", m0_gnt_o, 0);
        cyc(1, 32'h800, 1, 32'h700, 1, 0, 0, 0);
        chk1("viol3_m1_gnt", m1_gnt_o, 1);
        chk1("viol3_m0_gnt", m0_gnt_o, 0);
        chk32("viol3_addr", bus_addr_o, 32'h700);
        cyc(0, 0, 0, 0, 0, 1, 32'h7777, 0);
        chk1("viol4_m1_rvalid", m1_rvalid_o, 1);

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
